trng_packer: RTL
================

# trng_packer

Post-processing stage that consumes the per-period transition counts emitted by the coherent-sampling counter (`COUNT`/`COUNT_EN`) and turns them into a byte stream. It extracts one raw bit per count and runs two online health tests on the raw stream. It optionally applies von Neumann debiasing, packs the surviving bits into bytes, and buffers them in a small FIFO behind a valid/ready interface toward the host/UART side.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries; a power of two, 2..16.
- `RCT_LIMIT`, default 32: repetition-count alarm threshold on raw bits; range 2..255.
- `ZERO_LIMIT`, default 4: threshold for consecutive zero counts (dead oscillator); range 1..255.
- `CLK` in 1: the single system clock; all logic is on its rising edge.
- `RST` in 1: synchronous, active-low reset.
- `COUNT` in 8: transition count. Bit 7 is a sticky "≥128" flag, so `8'h00` means exactly zero transitions.
- `COUNT_EN` in 1: single-cycle strobe; `COUNT` is valid in that cycle.
- `DOUT` out 8: FIFO head byte. It reads `8'h00` whenever `DOUT_VALID` is low.
- `DOUT_VALID` out 1: the FIFO is non-empty.
- `DOUT_READY` in 1: the consumer accepts the head byte when `DOUT_VALID & DOUT_READY`.
- `ALARM` out 1: sticky health-test failure.
- `OVERRUN` out 1: sticky flag; a completed byte was dropped because the FIFO was full.

## Operation
- Reset (`RST`=0 at an edge) clears the following, regardless of any operation in progress:
  - the shift register and the bit counter;
  - the von Neumann pair state;
  - the run counters;
  - the FIFO pointers.
- Resulting output values after reset: `DOUT`=0, `DOUT_VALID`=0, `ALARM`=0, `OVERRUN`=0.
- On `COUNT_EN`=1, the sample is classified:
  - **Zero** (`COUNT`=0):
    - the zero-run counter increments, saturating at 255;
    - no raw bit is produced;
    - the repetition state is untouched.
  - **Non-zero**:
    - the zero-run counter clears;
    - raw bit r = `COUNT[0]`.
- Repetition-count test:
  - the run counter is loaded with 1 on the first raw bit after reset;
  - it is also loaded with 1 whenever r differs from the previous raw bit;
  - otherwise it increments, saturating at 255.
- `ALARM` sets on the edge where the run counter reaches `RCT_LIMIT`, or the zero-run counter reaches `ZERO_LIMIT`. Only reset clears it.
- Once `ALARM`=1:
  - no new byte is pushed, including the byte containing the alarming bit;
  - bit packing freezes;
  - the FIFO keeps draining normally.
- Packing: each accepted bit b updates `sr <= {sr[6:0], b}`, so the first bit ends up as the MSB of the byte.
  - A 3-bit counter counts accepted bits, wrapping from 7 to 0.
  - On the 8th bit, `{sr[6:0], b}` is pushed into the FIFO on that same edge.
- FIFO push/pop rules:
  - A push is accepted if the FIFO is not full, or a pop happens on the same edge.
  - Otherwise the byte is discarded, `OVERRUN` sets, and the bit counter still wraps.
  - A simultaneous push and pop on an empty FIFO is impossible, because pop requires `DOUT_VALID`.
- Pointers are `log2(FIFO_DEPTH)+1` bits wide, giving wrap-around full/empty detection.
- `COUNT_EN` strobes are at least ~960 cycles apart. The block must nevertheless accept back-to-back strobes.

## Timing
- Latency: from the `COUNT_EN` cycle carrying the 8th accepted bit, `DOUT_VALID`=1 and the byte on `DOUT` appear in the next cycle.
- A pop on edge k exposes the next entry on `DOUT` after edge k. `DOUT_VALID` drops after edge k if that pop emptied the FIFO.
- `ALARM` and `OVERRUN` assert one cycle after the offending `COUNT_EN` cycle.
- `DOUT`, `DOUT_VALID`, `ALARM` and `OVERRUN` are all registered or derived directly from registers. There is no combinational path from `DOUT_READY` to `DOUT_VALID`.

## Configuration
- Macro `TRNG_VON_NEUMANN_EN`.
- **Defined:** raw bits are paired.
  - The first bit of a pair is held in a pending register.
  - On the second bit: if the pair is (a,b) with a≠b, a is accepted into packing; if a=b, nothing is accepted.
  - In both cases the pending register clears.
  - Zero counts do not advance pairing.
  - The health tests always operate on raw bits, before pairing.
- **Undefined:** every raw bit goes directly to packing, and the pairing logic is absent.

## Test plan
- **Basic packing:** reset; 8 strobes with `COUNT` LSBs 1,0,1,1,0,0,1,0 (e.g. `8'h05`, `8'h82`, ...) and `DOUT_READY`=1 → one byte `8'hB2`, with `DOUT_VALID` high for exactly one cycle, one cycle after the 8th strobe. Run this without the macro.
- **Backpressure:** with `FIFO_DEPTH`=4 and `DOUT_READY`=0, feed 40 non-alarming bits → 4 bytes buffered and `OVERRUN`=1 after the 5th byte completes. Then raise `DOUT_READY` → exactly 4 bytes are drained in order, after which `DOUT_VALID`=0.
- **Repetition alarm:** with `RCT_LIMIT`=32, feed 32 strobes of `COUNT`=`8'h03` → `ALARM`=1 one cycle after the 32nd strobe, and no byte is pushed after the 24th bit. Assert `RST`=0 → `ALARM`=0.
- **Dead oscillator:** `ZERO_LIMIT`=4; 3 zeros, then `8'h80`, then 3 zeros → no alarm. A 4th consecutive zero → `ALARM`=1.
- **Von Neumann (macro defined):** raw pairs (0,1),(1,1),(1,0),(0,0) ×4 → 8 accepted bits 0,1,0,1,0,1,0,1 → `DOUT`=`8'h55`.
- **Mid-operation reset:** after 5 bits are packed and 2 bytes are queued, pulse `RST`=0 for one cycle → `DOUT_VALID`=0 next cycle. A following 8-bit sequence yields exactly one correct byte.

Source files
------------

// File: rtl/trng_packer_if.sv
// -----------------------------------------------------------------------------
// trng_packer_if
// Bundles the count-input, byte-output handshake and status signals of the
// TRNG packer.
//   master : the surrounding system. It drives COUNT/COUNT_EN/DOUT_READY and
//            observes DOUT/DOUT_VALID/ALARM/OVERRUN.
//   slave  : the packer itself.
// Signals:
//   COUNT[7:0]  transition count; bit 7 is a sticky ">=128" flag
//   COUNT_EN    single-cycle strobe qualifying COUNT
//   DOUT[7:0]   FIFO head byte, 8'h00 while DOUT_VALID is low
//   DOUT_VALID  FIFO non-empty
//   DOUT_READY  consumer accepts the head byte when DOUT_VALID & DOUT_READY
//   ALARM       sticky health-test failure
//   OVERRUN     sticky, a completed byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
interface trng_packer_if;
    logic [7:0] COUNT;
    logic       COUNT_EN;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY;
    logic       ALARM;
    logic       OVERRUN;

    modport master (
        output COUNT, COUNT_EN, DOUT_READY,
        input  DOUT, DOUT_VALID, ALARM, OVERRUN
    );

    modport slave (
        input  COUNT, COUNT_EN, DOUT_READY,
        output DOUT, DOUT_VALID, ALARM, OVERRUN
    );
endinterface : trng_packer_if

// File: rtl/trng_packer.sv
// -----------------------------------------------------------------------------
// trng_packer
// Turns per-period transition counts into a byte stream. One raw bit
// (COUNT[0]) is taken from every non-zero count. A repetition-count test and a
// dead-oscillator (zero-run) test watch the raw stream. Surviving bits are
// packed MSB-first into bytes and queued in a small FIFO.
// Optional feature: define TRNG_VON_NEUMANN_EN to insert von Neumann debiasing
// between the raw stream and the packer.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-low reset
//   bus  trng_packer_if.slave (COUNT/COUNT_EN in, DOUT/DOUT_VALID out,
//        DOUT_READY in, ALARM/OVERRUN out)
// Parameters: FIFO_DEPTH (power of two, 2..16), RCT_LIMIT (2..255),
//             ZERO_LIMIT (1..255)
// -----------------------------------------------------------------------------
module trng_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_LIMIT  = 32,
    parameter int ZERO_LIMIT = 4
) (
    input logic          CLK,
    input logic          RST,
    trng_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Extra MSB on the pointers separates full from empty when indices match.
    typedef logic [AW:0] ptr_t;

    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] zero_run_q, zero_run_d;
    logic [7:0] run_q, run_d;
    logic       last_bit_q, last_bit_d;
    logic       seen_bit_q, seen_bit_d;
    logic       alarm_q, alarm_d;
    logic       overrun_q, overrun_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic [7:0] mem_q [FIFO_DEPTH];

`ifdef TRNG_VON_NEUMANN_EN
    logic       pend_valid_q, pend_valid_d;
    logic       pend_bit_q, pend_bit_d;
`endif

    logic       is_zero, raw_valid, raw_bit;
    logic       alarm_set, acc_valid, acc_bit, accept;
    logic       push_req, push_ok, pop, empty, full;
    logic [7:0] push_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // NOTE: every signal gets a default at the top of always_comb, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        is_zero    = (bus.COUNT == 8'h00);
        raw_valid  = bus.COUNT_EN && !is_zero;
        raw_bit    = bus.COUNT[0];
        zero_run_d = zero_run_q;
        run_d      = run_q;
        last_bit_d = last_bit_q;
        seen_bit_d = seen_bit_q;

        // Health tests always run on the raw stream.
        if (bus.COUNT_EN) begin
            if (is_zero) begin
                if (zero_run_q != 8'hFF) zero_run_d = zero_run_q + 8'd1;
            end else begin
                zero_run_d = 8'h00;
                seen_bit_d = 1'b1;
                last_bit_d = raw_bit;
                if (!seen_bit_q || (raw_bit != last_bit_q)) begin
                    run_d = 8'd1;
                end else if (run_q != 8'hFF) begin
                    run_d = run_q + 8'd1;
                end
            end
        end

        alarm_set = (bus.COUNT_EN && is_zero && (zero_run_d == 8'(ZERO_LIMIT))) ||
                    (raw_valid && (run_d == 8'(RCT_LIMIT)));

`ifdef TRNG_VON_NEUMANN_EN
        pend_valid_d = pend_valid_q;
        pend_bit_d   = pend_bit_q;
        acc_valid    = 1'b0;
        acc_bit      = pend_bit_q;
        if (raw_valid) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_bit_d   = raw_bit;
            end else begin
                // Pair (a,b): emit a only when a != b; the pair is consumed either way.
                pend_valid_d = 1'b0;
                acc_valid    = (pend_bit_q != raw_bit);
            end
        end
`else
        acc_valid = raw_valid;
        acc_bit   = raw_bit;
`endif

        // The alarming bit itself is already frozen out of packing.
        accept    = acc_valid && !alarm_q && !alarm_set;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            sr_d      = {sr_q[5:0], acc_bit};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        push_req  = accept && (bit_cnt_q == 3'd7);
        push_data = {sr_q, acc_bit};
        pop       = !empty && bus.DOUT_READY;
        push_ok   = push_req && (!full || pop);

        wr_ptr_d  = push_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d  = pop     ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        overrun_d = overrun_q || (push_req && !push_ok);
        alarm_d   = alarm_q || alarm_set;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            zero_run_q   <= '0;
            run_q        <= '0;
            last_bit_q   <= 1'b0;
            seen_bit_q   <= 1'b0;
            alarm_q      <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
`ifdef TRNG_VON_NEUMANN_EN
            pend_valid_q <= 1'b0;
            pend_bit_q   <= 1'b0;
`endif
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            zero_run_q   <= zero_run_d;
            run_q        <= run_d;
            last_bit_q   <= last_bit_d;
            seen_bit_q   <= seen_bit_d;
            alarm_q      <= alarm_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
`ifdef TRNG_VON_NEUMANN_EN
            pend_valid_q <= pend_valid_d;
            pend_bit_q   <= pend_bit_d;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the pointers define which entries are
    // live, and DOUT is forced to zero while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push_ok && RST) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign bus.DOUT       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.DOUT_VALID = !empty;
    assign bus.ALARM      = alarm_q;
    assign bus.OVERRUN    = overrun_q;

endmodule : trng_packer
